// File: rtl/cfg_lock_sequencer_if.sv
// Request/response bundle between a config master and the lock sequencer.
// The master issues requests; the sequencer returns a one-cycle response.
interface cfg_lock_sequencer_if #(
    parameter int AW = 4
) ();
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [7:0]    req_data;
    logic          resp_valid;
    logic          resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_data,
        input  req_ready, resp_valid, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_data,
        output req_ready, resp_valid, resp_err
    );
endinterface

// File: rtl/cfg_lock_sequencer.sv
// Upstream control for a bank of lockable config registers. Accepts
// WRITE / ARM / COMMIT requests, enforces the keyed two-step lock with a
// timeout window, and mirrors which registers are locked so that writes
// to locked or out-of-range registers never strobe the bank.
module cfg_lock_sequencer #(
    parameter int         NUM_REGS   = 8,
    parameter int         AW         = 4,
    parameter logic [7:0] ARM_KEY    = 8'hA5,
    parameter logic [7:0] COMMIT_KEY = 8'h5A,
    parameter int         WINDOW     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    cfg_lock_sequencer_if.slave bus,
    output logic                arm_timeout,
    output logic [NUM_REGS-1:0] reg_wr_en,
    output logic [7:0]          reg_data,
    output logic [NUM_REGS-1:0] reg_lock_en,
    output logic [NUM_REGS-1:0] lock_status
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ISSUE = 2'd2
    } state_t;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_ARM    = 2'b01;
    localparam logic [1:0] OP_COMMIT = 2'b10;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [AW-1:0]       armed_addr_q, armed_addr_d;
    logic                to_armed_q, to_armed_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic                arm_timeout_q, arm_timeout_d;
    logic [NUM_REGS-1:0] reg_wr_en_q, reg_wr_en_d;
    logic [7:0]          reg_data_q, reg_data_d;
    logic [NUM_REGS-1:0] reg_lock_en_q, reg_lock_en_d;
    logic [NUM_REGS-1:0] lock_status_q, lock_status_d;

    // One-hot select; all-zero for an out-of-range index so it can never strobe.
    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [AW-1:0] a);
        addr_onehot = '0;
        if (32'(a) < NUM_REGS)
            addr_onehot = NUM_REGS'(1) << a;
    endfunction

    logic                accept;
    logic [NUM_REGS-1:0] req_sel;
    logic                req_in_range;
    logic                req_locked;

    assign accept       = bus.req_valid && req_ready_q;
    assign req_sel      = addr_onehot(bus.req_addr);
    assign req_in_range = (req_sel != '0);
    assign req_locked   = |(req_sel & lock_status_q);

    // Next-state and next-output decode; all outputs are registered so strobes
    // appear in the ISSUE cycle, one cycle after acceptance.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        armed_addr_d  = armed_addr_q;
        to_armed_d    = to_armed_q;
        lock_status_d = lock_status_q | reg_lock_en_q;
        resp_valid_d  = 1'b0;
        resp_err_d    = 1'b0;
        arm_timeout_d = 1'b0;
        reg_wr_en_d   = '0;
        reg_data_d    = '0;
        reg_lock_en_d = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = ISSUE;
                    resp_valid_d = 1'b1;
                    to_armed_d   = 1'b0;
                    case (bus.req_op)
                        OP_WRITE: begin
                            if (req_in_range && !req_locked) begin
                                reg_wr_en_d = req_sel;
                                reg_data_d  = bus.req_data;
                            end else begin
                                resp_err_d = 1'b1;
                            end
                        end
                        OP_ARM: begin
                            if (req_in_range && !req_locked && bus.req_data == ARM_KEY) begin
                                armed_addr_d = bus.req_addr;
                                cnt_d        = 8'(WINDOW);
                                to_armed_d   = 1'b1;
                            end else begin
                                resp_err_d = 1'b1;
                            end
                        end
                        default: resp_err_d = 1'b1;
                    endcase
                end
            end
            ARMED: begin
                if (accept) begin
                    // A request on the expiry edge wins over the timeout.
                    state_d      = ISSUE;
                    resp_valid_d = 1'b1;
                    to_armed_d   = 1'b0;
                    cnt_d        = '0;
                    if (bus.req_op == OP_COMMIT && bus.req_addr == armed_addr_q &&
                        bus.req_data == COMMIT_KEY) begin
                        reg_lock_en_d = addr_onehot(armed_addr_q);
                    end else begin
                        resp_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        cnt_d         = '0;
                        arm_timeout_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            ISSUE: begin
                state_d = to_armed_q ? ARMED : IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d != ISSUE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            armed_addr_q  <= '0;
            to_armed_q    <= 1'b0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            arm_timeout_q <= 1'b0;
            reg_wr_en_q   <= '0;
            reg_data_q    <= '0;
            reg_lock_en_q <= '0;
            lock_status_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            armed_addr_q  <= armed_addr_d;
            to_armed_q    <= to_armed_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            arm_timeout_q <= arm_timeout_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_data_q    <= reg_data_d;
            reg_lock_en_q <= reg_lock_en_d;
            lock_status_q <= lock_status_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign arm_timeout    = arm_timeout_q;
    assign reg_wr_en      = reg_wr_en_q;
    assign reg_data       = reg_data_q;
    assign reg_lock_en    = reg_lock_en_q;
    assign lock_status    = lock_status_q;

endmodule

// File: tb/tb_cfg_lock_sequencer.sv
// Scoreboard bench for cfg_lock_sequencer (NUM_REGS=8, WINDOW=16).
module tb_cfg_lock_sequencer;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_ARM    = 2'b01;
    localparam logic [1:0] OP_COMMIT = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef struct {
        logic       err;
        logic [7:0] wr;
        logic [7:0] lk;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm_timeout;
    logic [7:0] reg_wr_en;
    logic [7:0] reg_data;
    logic [7:0] reg_lock_en;
    logic [7:0] lock_status;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    cfg_lock_sequencer_if #(.AW(4)) bus ();

    cfg_lock_sequencer #(
        .NUM_REGS(8), .AW(4), .ARM_KEY(8'hA5), .COMMIT_KEY(8'h5A), .WINDOW(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .arm_timeout(arm_timeout),
        .reg_wr_en(reg_wr_en),
        .reg_data(reg_data),
        .reg_lock_en(reg_lock_en),
        .lock_status(lock_status)
    );

    always #5 clk = ~clk;

    // Response monitor: pops the scoreboard on every resp_valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.resp_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({bus.resp_err, reg_wr_en, reg_lock_en} !== {e.err, e.wr, e.lk}) begin
                        n_fail++;
                        $display("FAIL resp: got err=%b wr=%h lk=%h, want err=%b wr=%h lk=%h",
                                 bus.resp_err, reg_wr_en, reg_lock_en, e.err, e.wr, e.lk);
                    end
                    n_checks++;
                    if (e.wr != 8'h00 && reg_data !== e.data) begin
                        n_fail++;
                        $display("FAIL reg_data: got %h want %h", reg_data, e.data);
                    end
                    n_checks++;
                    if (bus.req_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL ready_in_issue: got %b want 0", bus.req_ready);
                    end
                end
            end else begin
                n_checks++;
                if (reg_wr_en !== 8'h00 || reg_lock_en !== 8'h00) begin
                    n_fail++;
                    $display("FAIL stray_strobe: wr=%h lk=%h want 00/00", reg_wr_en, reg_lock_en);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data,
                        input logic err, input logic [7:0] wr, input logic [7:0] lk);
        exp_t e;
        for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_wait: req_ready=%b want 1", bus.req_ready);
        end
        e.err = err; e.wr = wr; e.lk = lk; e.data = data;
        exp_q.push_back(e);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_data  = data;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL resp_missing: %0d outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, arm_timeout} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/rv/err/to=%b want 1000",
                     {bus.req_ready, bus.resp_valid, bus.resp_err, arm_timeout});
        end
        n_checks++;
        if ({reg_wr_en, reg_data, reg_lock_en, lock_status} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: wr=%h d=%h lk=%h ls=%h want 0",
                     reg_wr_en, reg_data, reg_lock_en, lock_status);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        send(OP_WRITE, 4'd3, 8'h3C, 1'b0, 8'b0000_1000, 8'h00);
        drain();
    endtask

    task automatic test_lock();
        send(OP_ARM, 4'd2, 8'hA5, 1'b0, 8'h00, 8'h00);
        drain();
        repeat (3) @(posedge clk);
        #1;
        send(OP_COMMIT, 4'd2, 8'h5A, 1'b0, 8'h00, 8'h04);
        drain();
        n_checks++;
        if (lock_status !== 8'h04) begin
            n_fail++;
            $display("FAIL lock_status_after_commit: got %h want 04", lock_status);
        end
        send(OP_WRITE, 4'd2, 8'h11, 1'b1, 8'h00, 8'h00);
        drain();
        send(OP_ARM, 4'd2, 8'hA5, 1'b1, 8'h00, 8'h00);
        drain();
    endtask

    task automatic test_timeout();
        int pulses;
        int first_at;
        pulses = 0;
        first_at = -1;
        send(OP_ARM, 4'd5, 8'hA5, 1'b0, 8'h00, 8'h00);
        drain();
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk);
            #1;
            if (arm_timeout === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        n_checks++;
        if (pulses != 1 || first_at != 16) begin
            n_fail++;
            $display("FAIL arm_timeout: pulses=%0d at=%0d want 1 at 16", pulses, first_at);
        end
        send(OP_COMMIT, 4'd5, 8'h5A, 1'b1, 8'h00, 8'h00);
        drain();
        n_checks++;
        if (lock_status !== 8'h04) begin
            n_fail++;
            $display("FAIL lock_after_timeout: got %h want 04", lock_status);
        end
    endtask

    task automatic test_bad_keys();
        send(OP_ARM, 4'd1, 8'hA5, 1'b0, 8'h00, 8'h00);
        drain();
        send(OP_COMMIT, 4'd4, 8'h5A, 1'b1, 8'h00, 8'h00);
        drain();
        send(OP_ARM, 4'd3, 8'h00, 1'b1, 8'h00, 8'h00);
        drain();
        // Still IDLE: a COMMIT now must be rejected.
        send(OP_COMMIT, 4'd3, 8'h5A, 1'b1, 8'h00, 8'h00);
        drain();
        // Bad COMMIT key while armed.
        send(OP_ARM, 4'd6, 8'hA5, 1'b0, 8'h00, 8'h00);
        drain();
        send(OP_COMMIT, 4'd6, 8'h55, 1'b1, 8'h00, 8'h00);
        drain();
        // Second ARM while armed disarms, so the following COMMIT fails.
        send(OP_ARM, 4'd6, 8'hA5, 1'b0, 8'h00, 8'h00);
        drain();
        send(OP_ARM, 4'd6, 8'hA5, 1'b1, 8'h00, 8'h00);
        drain();
        send(OP_COMMIT, 4'd6, 8'h5A, 1'b1, 8'h00, 8'h00);
        drain();
        n_checks++;
        if (lock_status !== 8'h04) begin
            n_fail++;
            $display("FAIL lock_after_bad_keys: got %h want 04", lock_status);
        end
    endtask

    task automatic test_range_rsvd();
        send(OP_WRITE, 4'd9, 8'h77, 1'b1, 8'h00, 8'h00);
        drain();
        send(OP_WRITE, 4'd15, 8'h77, 1'b1, 8'h00, 8'h00);
        drain();
        send(OP_ARM, 4'd8, 8'hA5, 1'b1, 8'h00, 8'h00);
        drain();
        send(OP_RSVD, 4'd0, 8'h00, 1'b1, 8'h00, 8'h00);
        drain();
    endtask

    task automatic test_back_to_back();
        send(OP_WRITE, 4'd0, 8'h01, 1'b0, 8'h01, 8'h00);
        send(OP_WRITE, 4'd7, 8'hFE, 1'b0, 8'h80, 8'h00);
        send(OP_WRITE, 4'd4, 8'h44, 1'b0, 8'h10, 8'h00);
        drain();
    endtask

    task automatic test_expiry_priority();
        int pulses;
        pulses = 0;
        send(OP_ARM, 4'd7, 8'hA5, 1'b0, 8'h00, 8'h00);
        drain();
        repeat (15) @(posedge clk);
        #1;
        send(OP_COMMIT, 4'd7, 8'h5A, 1'b0, 8'h00, 8'h80);
        for (int i = 0; i < 4; i++) begin
            if (arm_timeout === 1'b1) pulses++;
            @(posedge clk);
            #1;
        end
        drain();
        n_checks++;
        if (pulses != 0 || lock_status !== 8'h84) begin
            n_fail++;
            $display("FAIL expiry_priority: pulses=%0d ls=%h want 0 and 84", pulses, lock_status);
        end
    endtask

    task automatic test_reset_mid_arm();
        int pulses;
        pulses = 0;
        send(OP_ARM, 4'd0, 8'hA5, 1'b0, 8'h00, 8'h00);
        drain();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (arm_timeout === 1'b1 || bus.resp_valid === 1'b1) pulses++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (pulses != 0 || lock_status !== 8'h00 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_arm: events=%0d ls=%h ready=%b want 0, 00, 1",
                     pulses, lock_status, bus.req_ready);
        end
        send(OP_WRITE, 4'd0, 8'h5C, 1'b0, 8'h01, 8'h00);
        drain();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_addr  = 4'd0;
        bus.req_data  = 8'h00;
        test_reset();
        test_write();
        test_lock();
        test_timeout();
        test_bad_keys();
        test_range_rsvd();
        test_back_to_back();
        test_expiry_priority();
        test_reset_mid_arm();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cfg_lock_sequencer.md
Name: cfg_lock_sequencer

Overview:
- Upstream control stage for a bank of NUM_REGS lockable 8-bit config registers.
- Accepts config requests over a valid/ready port and drives each register's wr_en, data and lock_en.
- Enforces a two-step keyed lock protocol (ARM then COMMIT within a timeout window).
- Keeps a mirror of which registers are locked, so writes to locked or out-of-range registers are rejected before any strobe reaches the bank.

Parameters:
- NUM_REGS, 8, number of downstream lockable registers (2..16)
- AW, 4, request address width; must satisfy 2**AW >= NUM_REGS
- ARM_KEY, 8'hA5, data value required with an ARM op
- COMMIT_KEY, 8'h5A, data value required with a COMMIT op
- WINDOW, 16, cycles an ARM stays valid (1..255)

Ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_op  in  2  00 WRITE, 01 ARM, 10 COMMIT, 11 reserved
- req_addr  in  AW  target register index
- req_data  in  8  write data or key
- resp_valid  out  1  one-cycle response pulse
- resp_err  out  1  qualified by resp_valid; 1 = rejected
- arm_timeout  out  1  one-cycle pulse when an ARM window expires
- reg_wr_en  out  NUM_REGS  one-hot write strobe to the bank
- reg_data  out  8  write data to the bank
- reg_lock_en  out  NUM_REGS  one-hot lock strobe to the bank
- lock_status  out  NUM_REGS  mirror of locked registers

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; all outputs 0 except req_ready=1; window counter 0; armed_addr 0; lock_status cleared. Reset mid-ARM or mid-ISSUE aborts silently, with no response.
- Handshake: a request is accepted on a posedge with req_valid & req_ready. req_ready=1 in IDLE and ARMED, 0 in ISSUE.
- States: IDLE, ARMED, ISSUE. Every accepted request moves to ISSUE for exactly one cycle.
- In ISSUE: resp_valid=1, and any strobe is asserted in this same cycle (latency 1 from acceptance). Strobes and resp_valid are 0 in all other cycles. Next state: ARMED if the request was a successful ARM, else IDLE.
- WRITE, accepted from IDLE:
  - Error if req_addr >= NUM_REGS or lock_status[req_addr]=1.
  - Otherwise, in ISSUE: reg_wr_en[addr]=1, reg_data=req_data, resp_err=0.
  - On error: no strobe, resp_err=1.
- ARM, accepted from IDLE:
  - Succeeds if req_addr < NUM_REGS, req_data==ARM_KEY and that register is unlocked.
  - On success: store armed_addr, load counter=WINDOW, resp_err=0, then go to ARMED.
  - Otherwise resp_err=1, then go to IDLE.
- COMMIT, accepted from ARMED:
  - Succeeds if req_addr==armed_addr and req_data==COMMIT_KEY.
  - On success, in ISSUE: reg_lock_en[armed_addr]=1 and resp_err=0; lock_status[armed_addr] becomes 1 at the end of the ISSUE cycle.
  - Any mismatch: resp_err=1 and disarm.
- Any other request accepted in ARMED (WRITE, ARM, reserved op): resp_err=1, no strobe, disarm (go to IDLE via ISSUE).
- COMMIT or reserved op accepted in IDLE: resp_err=1.
- Window counter: decrements each ARMED cycle with no accepted request.
  - When it decrements from 1 to 0: arm_timeout=1 for one cycle, go to IDLE, no resp_valid.
  - A request accepted on the same edge as expiry takes priority; it is handled as if still ARMED, and arm_timeout is not pulsed.
- lock_status bits only set; they clear only on reset. Locking an already-locked register is impossible, because ARM rejects it.
- Out-of-range addresses never strobe any reg_wr_en or reg_lock_en bit.

Test Plan:
- Reset, then WRITE addr 3 data 8'h3C -> next cycle reg_wr_en=8'b0000_1000, reg_data=8'h3C, resp_valid=1, resp_err=0; req_ready=0 in that cycle.
- ARM addr 2 key A5, then after 3 idle cycles COMMIT addr 2 key 5A -> reg_lock_en[2] pulses, lock_status=8'h04; subsequent WRITE addr 2 -> resp_err=1, reg_wr_en stays 0.
- ARM addr 5 key A5, then no requests for 16 cycles -> arm_timeout pulses exactly once, state IDLE; later COMMIT addr 5 -> resp_err=1, no lock.
- ARM addr 1, then COMMIT addr 4 key 5A -> resp_err=1, no lock strobe; ARM with data 8'h00 -> resp_err=1, stays IDLE.
- WRITE addr 9 (NUM_REGS=8) -> resp_err=1, no strobe; op 11 -> resp_err=1.
- ARM addr 0, then assert rst_n=0 in the ARMED state -> no response, lock_status=0; after release, WRITE addr 0 succeeds.
